// File: rtl/mono_video_out.sv
// Output stage behind the ZX8X scandoubler: sync polarity normalisation, 1-bit to RGB666 mapping, blanking.
// Optional line counting and frame lock detection when VIDEO_OUT_LOCK_EN is defined.
module mono_video_out #(
    parameter int HCNT_W = 10,
    parameter int VCNT_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce_2pix,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic              v_in,
    input  logic              inverse,
    input  logic [17:0]       fg_rgb,
    input  logic [17:0]       bg_rgb,
    output logic [5:0]        r,
    output logic [5:0]        g,
    output logic [5:0]        b,
    output logic              hs_out,
    output logic              vs_out,
    output logic              locked,
    output logic [VCNT_W-1:0] lines
);

    function automatic logic [HCNT_W-1:0] hinc(input logic [HCNT_W-1:0] x);
        return (x == '1) ? x : x + 1'b1;
    endfunction

    function automatic logic [VCNT_W-1:0] vinc(input logic [VCNT_W-1:0] x);
        return (x == '1) ? x : x + 1'b1;
    endfunction

    logic              hs_d, vs_d, v_d, hs_dd, vs_dd;
    logic [HCNT_W-1:0] hs_hi, hs_lo, hi_len;
    logic [VCNT_W-1:0] vs_hi, vs_lo, vhi_len;
    logic              hs_neg, vs_neg;
    logic              hs_rise, hs_fall, vs_rise, vs_fall;
    logic              hs_n, vs_n;
    logic [17:0]       colour;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_d  <= 1'b0;
            vs_d  <= 1'b0;
            v_d   <= 1'b0;
            hs_dd <= 1'b0;
            vs_dd <= 1'b0;
        end else if (ce_2pix) begin
            hs_d  <= hs_in;
            vs_d  <= vs_in;
            v_d   <= v_in;
            hs_dd <= hs_d;
            vs_dd <= vs_d;
        end
    end

    assign hs_rise = hs_d & ~hs_dd;
    assign hs_fall = ~hs_d & hs_dd;
    assign vs_rise = vs_d & ~vs_dd;
    assign vs_fall = ~vs_d & vs_dd;

    // The low-period length is compared straight from the running counter on the
    // rising edge, so it never needs a latch of its own.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_hi   <= '0;
            hs_lo   <= '0;
            hi_len  <= '0;
            hs_neg  <= 1'b0;
            vs_hi   <= '0;
            vs_lo   <= '0;
            vhi_len <= '0;
            vs_neg  <= 1'b0;
        end else if (ce_2pix) begin
            hs_hi <= hs_d ? hinc(hs_hi) : '0;
            hs_lo <= hs_d ? '0 : hinc(hs_lo);
            if (hs_fall)
                hi_len <= hs_hi;
            if (hs_rise && (hi_len != hs_lo))
                hs_neg <= (hi_len > hs_lo);

            if (vs_d) begin
                vs_hi <= hs_rise ? vinc(vs_hi) : vs_hi;
                vs_lo <= '0;
            end else begin
                vs_hi <= '0;
                vs_lo <= hs_rise ? vinc(vs_lo) : vs_lo;
            end
            if (vs_fall)
                vhi_len <= vs_hi;
            if (vs_rise && (vhi_len != vs_lo))
                vs_neg <= (vhi_len > vs_lo);
        end
    end

    assign hs_n = hs_d ^ hs_neg;
    assign vs_n = vs_d ^ vs_neg;

    always_comb begin
        colour = (v_d ^ inverse) ? fg_rgb : bg_rgb;
        if (hs_n || vs_n)
            colour = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r      <= '0;
            g      <= '0;
            b      <= '0;
            hs_out <= 1'b0;
            vs_out <= 1'b0;
        end else if (ce_2pix) begin
            r      <= colour[17:12];
            g      <= colour[11:6];
            b      <= colour[5:0];
            hs_out <= hs_n;
            vs_out <= vs_n;
        end
    end

`ifdef VIDEO_OUT_LOCK_EN
    logic [VCNT_W-1:0] line_cnt;
    logic [1:0]        match_cnt;

    // hs_out/vs_out hold the previous hs_n/vs_n, giving the edge reference for free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_cnt  <= '0;
            lines     <= '0;
            match_cnt <= '0;
        end else if (ce_2pix) begin
            if (vs_n && !vs_out) begin
                lines    <= line_cnt;
                line_cnt <= '0;
                if ((line_cnt == lines) && (line_cnt != '0))
                    match_cnt <= (match_cnt == 2'd3) ? match_cnt : match_cnt + 2'd1;
                else
                    match_cnt <= '0;
            end else if (hs_n && !hs_out) begin
                line_cnt <= vinc(line_cnt);
            end
        end
    end

    assign locked = (match_cnt == 2'd3);
`else
    assign lines  = '0;
    assign locked = 1'b1;
`endif

endmodule
